// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter.
// A small FIFO feeds a frame FSM (IDLE -> START -> DATA -> STOP). A frame
// starts on the edge after the FIFO becomes non-empty, and frames are
// chained with no gap while bytes remain buffered.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit after
// data bit 7, which gives an 11-bit frame.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is set one cycle early in order to be high
    // during the last cycle of the stop bit.
    localparam logic [CW-1:0] DONE_AT  = CW'(CLKS_PER_BIT - 2);
    localparam logic [PW:0]   OCC_FULL = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          tx_ready_q;
    logic          push, pop;
    logic [7:0]    head;

    // ---------------- FSM ----------------
    state_t        state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          tx_done_q;
    logic          bit_last;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    assign bit_last = (bit_cnt_q == BIT_LAST);
    assign head     = mem_q[rd_ptr_q];
    // The write is gated by the registered ready, so a pop in the same cycle
    // cannot make room for a write while the FIFO is full.
    assign push     = tx_valid && tx_ready_q;
    assign pop      = (cnt_q != '0) &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_last));

    // Next pointers and occupancy; a simultaneous push and pop leave occupancy unchanged
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO bookkeeping; ready is registered from the next occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tx_ready_q <= (cnt_d != OCC_FULL);
        end
    end

    // FIFO storage; contents are only meaningful when occupancy covers them
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // Frame sequencer; the byte is latched into the shift register at pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_done_q <= (state_q == S_STOP) && (bit_cnt_q == DONE_AT);
            case (state_q)
                S_IDLE: begin
                    bit_cnt_q <= '0;
                    if (pop) begin
                        shift_q   <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^head;
`endif
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        // Chain straight into the next start bit when data is waiting
                        if (pop) begin
                            shift_q   <= head;
`ifdef UART_TX_PARITY_EN
                            parity_q  <= ^head;
`endif
                            bit_idx_q <= '0;
                            tx_q      <= 1'b0;
                            state_q   <= S_START;
                        end else begin
                            tx_q      <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                default: begin
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;
    assign busy     = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs are driven and outputs are sampled on the falling edge. The frame
// task walks a frame one cycle at a time, checks each bit at mid-period and
// checks the tx_done pulse position.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Count every cycle in which tx_done is high
    always @(posedge clk) if (tx_done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at frame cycle 'skip' (cycle 0 = first cycle of the start bit);
    // returns at frame cycle FRAME, which is the first cycle after the stop bit.
    task automatic frame(input logic [7:0] b, input int skip, input bit inj, input logic [7:0] ib);
        logic [10:0] fv;
`ifdef UART_TX_PARITY_EN
        fv = {1'b1, ^b, b, 1'b0};
`else
        fv = {1'b0, 1'b1, b, 1'b0};
`endif
        for (int fc = skip; fc <= FRAME; fc++) begin
            if (fc > skip) @(negedge clk);
            if ((fc % CPB == CPB / 2) && (fc < FRAME))
                chk($sformatf("bit%0d_of_%02h", fc / CPB, b), 32'(tx), 32'(fv[fc / CPB]));
            if (fc == FRAME - 2) chk($sformatf("done_early_%02h", b), 32'(tx_done), 32'd0);
            if (fc == FRAME - 1) begin
                chk($sformatf("done_pulse_%02h", b), 32'(tx_done), 32'd1);
                if (inj) begin
                    tx_valid = 1'b1;
                    tx_data  = ib;
                end
            end
            if (fc == FRAME) begin
                chk($sformatf("done_clear_%02h", b), 32'(tx_done), 32'd0);
                if (inj) begin
                    tx_valid = 1'b0;
                    chk("occ_hold", 32'(dut.cnt_q), 32'd3);
                    chk("ready_occ3", 32'(tx_ready), 32'd1);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte: tx must go low one edge after the accepting edge
        tx_valid = 1'b1; tx_data = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("lat_edge_n", 32'(tx), 32'd1);
        chk("busy_queued", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_edge_n1", 32'(tx), 32'd0);
        d0 = done_cnt;
        frame(8'hA5, 0, 1'b0, 8'h00);
        chk("idle_tx_a5", 32'(tx), 32'd1);
        chk("idle_busy_a5", 32'(busy), 32'd0);
        chk("done_count_a5", 32'(done_cnt - d0), 32'd1);

        // Four writes on consecutive cycles, sent back to back
        d0 = done_cnt;
        tx_valid = 1'b1; tx_data = 8'h01; @(negedge clk);
        chk("b2b_tx_w1", 32'(tx), 32'd1);
        chk("b2b_ready_w1", 32'(tx_ready), 32'd1);
        tx_data = 8'h02; @(negedge clk);
        chk("b2b_tx_w2", 32'(tx), 32'd0);
        tx_data = 8'h03; @(negedge clk);
        chk("b2b_ready_w3", 32'(tx_ready), 32'd1);
        tx_data = 8'h04; @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_ready_w4", 32'(tx_ready), 32'd1);
        frame(8'h01, 2, 1'b0, 8'h00);
        frame(8'h02, 0, 1'b0, 8'h00);
        frame(8'h03, 0, 1'b0, 8'h00);
        frame(8'h04, 0, 1'b0, 8'h00);
        chk("b2b_idle_tx", 32'(tx), 32'd1);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd4);

        // Fill FIFO with one frame in flight, then a write while full is dropped
        tx_valid = 1'b1; tx_data = 8'h10; @(negedge clk);
        tx_data = 8'h11; @(negedge clk);
        tx_data = 8'h12; @(negedge clk);
        tx_data = 8'h13; @(negedge clk);
        tx_data = 8'h14; @(negedge clk);
        chk("full_ready_lo", 32'(tx_ready), 32'd0);
        tx_data = 8'hFF; @(negedge clk);
        chk("full_ready_hold", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        frame(8'h10, 4, 1'b0, 8'h00);
        chk("full_ready_back", 32'(tx_ready), 32'd1);
        frame(8'h11, 0, 1'b0, 8'h00);
        frame(8'h12, 0, 1'b0, 8'h00);
        frame(8'h13, 0, 1'b0, 8'h00);
        frame(8'h14, 0, 1'b0, 8'h00);
        chk("full_idle_tx", 32'(tx), 32'd1);
        chk("full_idle_busy", 32'(busy), 32'd0);

        // Three buffered entries; write coincides with pop at end of stop
        tx_valid = 1'b1; tx_data = 8'h20; @(negedge clk);
        tx_data = 8'h21; @(negedge clk);
        tx_data = 8'h22; @(negedge clk);
        tx_data = 8'h23; @(negedge clk);
        tx_valid = 1'b0;
        chk("occ3_before", 32'(dut.cnt_q), 32'd3);
        frame(8'h20, 2, 1'b1, 8'h24);
        frame(8'h21, 0, 1'b0, 8'h00);
        frame(8'h22, 0, 1'b0, 8'h00);
        frame(8'h23, 0, 1'b0, 8'h00);
        frame(8'h24, 0, 1'b0, 8'h00);
        chk("occ_idle_busy", 32'(busy), 32'd0);

        // Reset during data bit 3 of 0x3C aborts the frame
        tx_valid = 1'b1; tx_data = 8'h3C; @(negedge clk);
        tx_valid = 1'b0; @(negedge clk);
        chk("abort_start", 32'(tx), 32'd0);
        repeat (17) @(negedge clk);
        chk("abort_bit3", 32'(tx), 32'd1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        chk("abort_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle_tx", 32'(tx), 32'd1);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        tx_valid = 1'b1; tx_data = 8'h55; @(negedge clk);
        tx_valid = 1'b0;
        chk("post_rst_lat_n", 32'(tx), 32'd1);
        @(negedge clk);
        frame(8'h55, 0, 1'b0, 8'h00);

        // Parity-sensitive bytes (odd and zero weight)
        tx_valid = 1'b1; tx_data = 8'h07; @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'h00; @(negedge clk);
        frame(8'h07, 0, 1'b0, 8'h00);
        tx_valid = 1'b1; tx_data = 8'h00; @(negedge clk);
        tx_valid = 1'b0; @(negedge clk);
        frame(8'h00, 0, 1'b0, 8'h00);
        chk("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
